// File: rtl/tb_pkg.sv
// Shared types for the N x N streaming transpose buffer.
// Holds the FSM state enum, shift-direction enum and bus width helper.
package tb_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } tb_state_e;

    typedef enum logic {
        ROW = 1'b0,
        COL = 1'b1
    } tb_dir_e;

    function automatic int bus_width(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/tb_mux_cell.sv
// One storage cell of the transpose array: DATAWIDTH register with
// sync reset, shift enable and a row/column neighbour select.
// Ports: clock, reset, en (shift), sel (ROW/COL),
//        row_nb / col_nb (neighbour values), q (stored sample).
module tb_mux_cell
    import tb_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  tb_dir_e              sel,
    input  logic [DATAWIDTH-1:0] row_nb,
    input  logic [DATAWIDTH-1:0] col_nb,
    output logic [DATAWIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= (sel == ROW) ? row_nb : col_nb;
        end
    end

endmodule

// File: rtl/transpose_buffer_nxn.sv
// N x N streaming transpose buffer: loads one row per beat and emits the
// previous block (transposed or bypassed) while the next one loads.
// Ports: clock, reset (sync, active-high); in_valid/in_ready/in_data/
//        in_mode input stream; flush drain request; out_valid/out_ready/
//        out_data/out_last output stream; busy = block resident or draining.
module transpose_buffer_nxn
    import tb_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int N         = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [bus_width(N, DATAWIDTH)-1:0]   in_data,
    input  logic                                 in_mode,
    input  logic                                 flush,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [bus_width(N, DATAWIDTH)-1:0]   out_data,
    output logic                                 out_last,
    output logic                                 busy
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    tb_state_e     state, state_nx;
    tb_dir_e       dir, dir_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          mode_q, mode_q_nx;
    logic          pend, pend_nx;

    logic take;
    logic drain_beat;
    logic shift;
    logic blk_end;

    logic [N-1:0][DATAWIDTH-1:0] src;
    logic [DATAWIDTH-1:0]        cells [N][N];

    // Handshake decode
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        unique case (state)
            FILL: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            STREAM: begin
                in_ready  = out_ready;
                out_valid = in_valid;
            end
            DRAIN: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    assign take       = in_valid & in_ready;
    assign drain_beat = (state == DRAIN) & out_ready;
    assign shift      = take | drain_beat;
    assign blk_end    = shift & (cnt == LAST);

    // Zeros enter the load edge while draining
    assign src = (state == DRAIN) ? '0 : in_data;

    // Control next-state
    always_comb begin
        state_nx  = state;
        dir_nx    = dir;
        cnt_nx    = cnt;
        mode_q_nx = mode_q;
        pend_nx   = pend;

        // A flush with nothing loaded has nothing to drain
        if (flush && !(state == FILL && cnt == '0)) begin
            pend_nx = 1'b1;
        end

        if (take && cnt == '0) begin
            mode_q_nx = in_mode;
        end

        if (shift) begin
            cnt_nx = (cnt == LAST) ? '0 : cnt + CW'(1);
        end

        unique case (state)
            FILL: begin
                if (blk_end) begin
                    dir_nx   = tb_dir_e'(dir ^ mode_q);
                    state_nx = pend_nx ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (blk_end) begin
                    dir_nx = tb_dir_e'(dir ^ mode_q);
                end
                // Drain only on a block boundary
                if (cnt_nx == '0 && pend_nx) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (blk_end) begin
                    state_nx = FILL;
                    dir_nx   = ROW;
                    cnt_nx   = '0;
                    pend_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= FILL;
            dir    <= ROW;
            cnt    <= '0;
            mode_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            state  <= state_nx;
            dir    <= dir_nx;
            cnt    <= cnt_nx;
            mode_q <= mode_q_nx;
            pend   <= pend_nx;
        end
    end

    // Array: ROW shifts toward row 0, COL shifts toward column 0.
    // Loading in one direction and reading in the other transposes.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [DATAWIDTH-1:0] row_nb;
            logic [DATAWIDTH-1:0] col_nb;

            if (r == N - 1) begin : g_row_edge
                assign row_nb = src[c];
            end else begin : g_row_in
                assign row_nb = cells[r+1][c];
            end

            if (c == N - 1) begin : g_col_edge
                assign col_nb = src[r];
            end else begin : g_col_in
                assign col_nb = cells[r][c+1];
            end

            tb_mux_cell #(
                .DATAWIDTH(DATAWIDTH)
            ) u_cell (
                .clock  (clock),
                .reset  (reset),
                .en     (shift),
                .sel    (dir),
                .row_nb (row_nb),
                .col_nb (col_nb),
                .q      (cells[r][c])
            );
        end
    end

    // Far edge of the array is the output beat
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++) begin
            if (dir == ROW) begin
                out_data[k*DATAWIDTH +: DATAWIDTH] = cells[0][k];
            end else begin
                out_data[k*DATAWIDTH +: DATAWIDTH] = cells[k][0];
            end
        end
    end

    assign out_last = (state != FILL) && (cnt == LAST);
    assign busy     = (state != FILL) || pend;

endmodule

// File: tb/tb_transpose_buffer_nxn.sv
// Self-checking bench for transpose_buffer_nxn (N=4, DATAWIDTH=8).
// Directed vector table, hand sequences and a queue-based reference model.
module tb_transpose_buffer_nxn;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BW = N * DW;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_mode;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int tests;
    int fails;

    transpose_buffer_nxn #(
        .DATAWIDTH(DW),
        .N        (N)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [BW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic [BW-1:0] rows [N];
    int            mcnt;
    logic          mmode;
    bit            pend;
    bit            drn;
    int            nout;

    task automatic model_clear();
        exp_q.delete();
        mcnt  = 0;
        mmode = 1'b0;
        pend  = 1'b0;
        drn   = 1'b0;
    endtask

    task automatic step(input logic iv, input logic [BW-1:0] d,
                        input logic m, input logic orr, input logic fl);
        bit    fill, eir, eov, acc, outx;
        beat_t bt;
        @(negedge clock);
        in_valid  = iv;
        in_data   = d;
        in_mode   = m;
        out_ready = orr;
        flush     = fl;
        #1;
        fill = (exp_q.size() == 0) && !drn;
        eir  = drn ? 1'b0 : (fill ? 1'b1 : orr);
        eov  = drn ? 1'b1 : (fill ? 1'b0 : iv);
        chk("in_ready", in_ready, eir);
        chk("out_valid", out_valid, eov);
        chk("busy", busy, !fill || pend);
        acc  = iv && eir;
        outx = eov && orr;
        if (outx) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_last", out_last, exp_q[0].l);
                void'(exp_q.pop_front());
                nout++;
            end
        end
        if (fl && !(fill && mcnt == 0)) pend = 1'b1;
        if (acc) begin
            rows[mcnt] = d;
            if (mcnt == 0) mmode = m;
            mcnt++;
            if (mcnt == N) begin
                for (int b = 0; b < N; b++) begin
                    bt.d = '0;
                    for (int k = 0; k < N; k++) begin
                        bt.d[k*DW +: DW] = mmode ? rows[k][b*DW +: DW]
                                                 : rows[b][k*DW +: DW];
                    end
                    bt.l = (b == N - 1);
                    exp_q.push_back(bt);
                end
                mcnt = 0;
            end
        end
        if (drn && exp_q.size() == 0) begin
            drn  = 1'b0;
            pend = 1'b0;
        end else if (!drn && exp_q.size() != 0 && mcnt == 0 && pend) begin
            drn = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    function automatic logic [BW-1:0] arow(input int i, input int base);
        logic [BW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = 8'(base + 16 * i + j);
        return v;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic          iv;
        logic [BW-1:0] d;
        logic          m;
        logic          orr;
        logic          fl;
        logic          e_ir;
        logic          e_ov;
        logic [BW-1:0] e_od;
        logic          e_ol;
        logic          e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic [BW-1:0] d, input logic m,
        input logic orr, input logic fl, input logic e_ir,
        input logic e_ov, input logic [BW-1:0] e_od,
        input logic e_ol, input logic e_busy);
        vec_t v;
        v.iv = iv; v.d = d; v.m = m; v.orr = orr; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
        v.e_ol = e_ol; v.e_busy = e_busy;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        tests     = 0;
        fails     = 0;
        nout      = 0;
        model_clear();

        // A transpose, B bypass, C transpose, flush drains C
        tbl[0]  = mk(1, 32'h03020100, 1, 1, 0, 1, 0, 32'h0,        0, 0);
        tbl[1]  = mk(1, 32'h13121110, 1, 1, 0, 1, 0, 32'h0,        0, 0);
        tbl[2]  = mk(1, 32'h23222120, 1, 1, 0, 1, 0, 32'h0,        0, 0);
        tbl[3]  = mk(1, 32'h33323130, 1, 1, 0, 1, 0, 32'h0,        0, 0);
        tbl[4]  = mk(1, 32'h83828180, 0, 1, 0, 1, 1, 32'h30201000, 0, 1);
        tbl[5]  = mk(1, 32'h93929190, 0, 1, 0, 1, 1, 32'h31211101, 0, 1);
        tbl[6]  = mk(1, 32'hA3A2A1A0, 0, 1, 0, 1, 1, 32'h32221202, 0, 1);
        tbl[7]  = mk(1, 32'hB3B2B1B0, 0, 1, 0, 1, 1, 32'h33231303, 1, 1);
        tbl[8]  = mk(1, 32'h43424140, 1, 1, 0, 1, 1, 32'h83828180, 0, 1);
        tbl[9]  = mk(1, 32'h53525150, 1, 1, 0, 1, 1, 32'h93929190, 0, 1);
        tbl[10] = mk(1, 32'h63626160, 1, 1, 0, 1, 1, 32'hA3A2A1A0, 0, 1);
        tbl[11] = mk(1, 32'h73727170, 1, 1, 0, 1, 1, 32'hB3B2B1B0, 1, 1);
        tbl[12] = mk(0, 32'h0,        0, 1, 0, 1, 0, 32'h70605040, 0, 1);
        tbl[13] = mk(0, 32'h0,        0, 1, 1, 1, 0, 32'h70605040, 0, 1);
        tbl[14] = mk(1, 32'hDEADBEEF, 0, 1, 0, 0, 1, 32'h70605040, 0, 1);
        tbl[15] = mk(1, 32'hDEADBEEF, 0, 1, 0, 0, 1, 32'h71615141, 0, 1);
        tbl[16] = mk(1, 32'hDEADBEEF, 0, 1, 0, 0, 1, 32'h72625242, 0, 1);
        tbl[17] = mk(1, 32'hDEADBEEF, 0, 1, 0, 0, 1, 32'h73635343, 1, 1);
        tbl[18] = mk(0, 32'h0,        0, 1, 0, 1, 0, 32'h0,        0, 0);

        // Reset held with in_valid high
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hFFFFFFFF;
        in_mode   = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_busy", busy, 0);
        end
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_cnt", 32'(dut.cnt), 0);
        chk("rst_state", 32'(dut.state), 0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                chk("rst_cell", 32'(dut.cells[r][c]), 0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            in_mode   = tbl[i].m;
            out_ready = tbl[i].orr;
            flush     = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].e_ol);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end
        chk("drain_state", 32'(dut.state), 0);
        chk("drain_dir", 32'(dut.dir), 0);

        // Bypass: dir unchanged, rows out in order
        do_reset();
        for (int i = 0; i < N; i++) step(1, arow(i, 0), 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("byp_dir", 32'(dut.dir), 0);
        chk("byp_beat0", out_data, 32'h03020100);
        for (int i = 0; i < N; i++) step(1, arow(i, 8'h80), 0, 1, 0);

        // Backpressure mid-block
        do_reset();
        for (int i = 0; i < N; i++) step(1, arow(i, 0), 1, 1, 0);
        nout = 0;
        step(1, arow(0, 8'h80), 1, 1, 0);
        step(1, arow(1, 8'h80), 1, 1, 0);
        repeat (3) step(1, arow(2, 8'h80), 1, 0, 0);
        step(1, arow(2, 8'h80), 1, 1, 0);
        step(1, arow(3, 8'h80), 1, 1, 0);
        chk("bp_beats", nout, N);

        // Reset mid-block, then C and D
        do_reset();
        for (int i = 0; i < N; i++) step(1, arow(i, 0), 1, 1, 0);
        step(1, arow(0, 8'h80), 1, 1, 0);
        step(1, arow(1, 8'h80), 1, 1, 0);
        do_reset();
        #1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                chk("mid_rst_cell", 32'(dut.cells[r][c]), 0);
        for (int i = 0; i < N; i++) step(1, arow(i, 8'h40), 1, 1, 0);
        step(1, arow(0, 8'hC0), 0, 1, 0);
        chk("mid_c_beat0_seen", nout > 0, 1);

        // Random traffic with occasional flushes
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
